pla_bist_ctrl: RTL

- Hardware self-test sequencer for the on-chip C64 PLA replacement.
- Walks all 2^IN_W input vectors on the PLA i-lines and holds chip enable active for the whole run.
- Compares the DUT f-lines against a reference PLA output after a settle window, counts mismatches, and captures the first failing vector.
- Sits next to the PLA design inside chip_top, so the pad-level exhaustive check can also run in silicon.

---
 rtl/pla_bist_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pla_bist_ctrl.sv
// Exhaustive self-test sequencer for the PLA: walks every i-line vector, compares
// DUT f-lines against a reference after a settle window, and logs mismatches.
module pla_bist_ctrl #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  pla_i,
  output logic             pla_cen_n,
  input  logic [OUT_W-1:0] dut_f,
  input  logic [OUT_W-1:0] ref_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic [OUT_W-1:0] first_fail_dut,
  output logic [OUT_W-1:0] first_fail_ref,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [IN_W-1:0]   pla_i_q, pla_i_d;
  logic              cen_n_q, cen_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fv_q, fv_d;
  logic [IN_W-1:0]   ff_vec_q, ff_vec_d;
  logic [OUT_W-1:0]  ff_dut_q, ff_dut_d;
  logic [OUT_W-1:0]  ff_ref_q, ff_ref_d;

  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  assign mismatch = (dut_f != ref_f);
  assign err_next = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;

  // start and abort are plain level controls sampled on each rising edge; there is
  // no handshake: start is honoured only in IDLE/DONE, abort only while a run is
  // active, and abort wins whenever both are high.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pla_i_d  = pla_i_q;
    cen_n_d  = cen_n_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_vec_d = ff_vec_q;
    ff_dut_d = ff_dut_q;
    ff_ref_d = ff_ref_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d  = S_APPLY;
          settle_d = '0;
          pla_i_d  = '0;
          cen_n_d  = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fv_d     = 1'b0;
          ff_vec_d = '0;
          ff_dut_d = '0;
          ff_ref_d = '0;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
          cen_n_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          settle_d = settle_q + SC_W'(1);
          if (settle_q == SC_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          cen_n_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          err_d = err_next;
          if (mismatch && !fv_q) begin
            fv_d     = 1'b1;
            ff_vec_d = pla_i_q;
            ff_dut_d = dut_f;
            ff_ref_d = ref_f;
          end
          // Terminal vector ends the run instead of wrapping pla_i back to zero.
          if (pla_i_q == '1) begin
            state_d = S_DONE;
            cen_n_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end else begin
            state_d  = S_APPLY;
            pla_i_d  = pla_i_q + IN_W'(1);
            settle_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      pla_i_q  <= '0;
      cen_n_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ff_vec_q <= '0;
      ff_dut_q <= '0;
      ff_ref_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pla_i_q  <= pla_i_d;
      cen_n_q  <= cen_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ff_vec_q <= ff_vec_d;
      ff_dut_q <= ff_dut_d;
      ff_ref_q <= ff_ref_d;
    end
  end

  assign pla_i          = pla_i_q;
  assign pla_cen_n      = cen_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_dut = ff_dut_q;
  assign first_fail_ref = ff_ref_q;
  assign dbg_state      = state_q;

endmodule
